stream_reorder: RTL and testbench

Parametrised streaming sample reorder for the pipelined FFT commutator path. Frames of N = 2^LOG2N samples are accepted serially, stored in a two-bank ping-pong buffer and emitted at one sample per cycle in a permuted order chosen per frame: pass-through, even/odd split, or bit-reversed. It sits between FFT butterfly stages, or at the FFT output for natural-order unscrambling, and replaces the fixed 16-point even/odd remap with a configurable-length, handshaked version.

---
 rtl/stream_reorder_pkg.sv | 28 ++
 rtl/stream_reorder_if.sv | 15 +
 rtl/stream_reorder_addr_gen.sv | 24 ++
 rtl/stream_reorder.sv | 106 ++++++++++
 tb/tb_stream_reorder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/stream_reorder_pkg.sv
// Shared types and helpers for the stream_reorder frame permuter.
// Optional feature macro: STREAM_REORDER_BITREV_EN (enables mode 2 bit-reverse).
package stream_reorder_pkg;

   localparam int MAX_LOG2N = 10;

   typedef enum logic [1:0] {
      REORDER_PASS    = 2'd0,
      REORDER_EVENODD = 2'd1,
      REORDER_BITREV  = 2'd2
   } reorder_mode_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

   // Reverses the low n bits of v; bits at and above n come back as zero.
   function automatic logic [MAX_LOG2N-1:0] bit_rev(input logic [MAX_LOG2N-1:0] v,
                                                    input int n);
      logic [MAX_LOG2N-1:0] r;
      r = '0;
      for (int k = 0; k < MAX_LOG2N; k++)
         if (k < n) r[k] = v[n-1-k];
      return r;
   endfunction

endpackage

// File: rtl/stream_reorder_if.sv
// Sample stream bus for stream_reorder: frame input side and reordered output side.
interface stream_reorder_if #(parameter int DW = 16);
   logic          start;
   logic [1:0]    mode;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_first;
   logic [DW-1:0] out_data;

   modport master (output start, mode, in_valid, in_data,
                   input  out_valid, out_first, out_data);
   modport slave  (input  start, mode, in_valid, in_data,
                   output out_valid, out_first, out_data);
endinterface

// File: rtl/stream_reorder_addr_gen.sv
// Combinational read-address permutation for stream_reorder.
// Macro STREAM_REORDER_BITREV_EN: when undefined, mode 2 degrades to pass-through.
module reorder_addr_gen
   import stream_reorder_pkg::*;
#(
   parameter int LOG2N = 4
) (
   input  logic [1:0]       mode,
   input  logic [LOG2N-1:0] rd_idx,
   output logic [LOG2N-1:0] addr
);

   always_comb begin
      addr = rd_idx;
      case (mode)
         REORDER_EVENODD: addr = {rd_idx[LOG2N-2:0], rd_idx[LOG2N-1]};
`ifdef STREAM_REORDER_BITREV_EN
         REORDER_BITREV:  addr = LOG2N'(bit_rev(MAX_LOG2N'(rd_idx), LOG2N));
`endif
         default:         addr = rd_idx;
      endcase
   end

endmodule

// File: rtl/stream_reorder.sv
// Ping-pong frame buffer emitting each completed frame in a per-frame permuted order.
// Bit-reverse mode is present only with STREAM_REORDER_BITREV_EN defined.
module stream_reorder
   import stream_reorder_pkg::*;
#(
   parameter int DW    = 16,
   parameter int LOG2N = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   stream_reorder_if.slave  bus
);

   localparam int               N    = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   logic [DW-1:0]    mem [2*N];
   logic [LOG2N-1:0] wr_idx, wr_addr, rd_idx, rd_addr;
   logic             wr_bank, rd_bank;
   logic [1:0]       frame_mode, rd_mode;
   logic             complete;
   rd_state_e        state;
   logic             out_valid_q, out_first_q;
   logic [DW-1:0]    out_data_q;

   // A start with a sample makes that sample index 0 of the new frame.
   assign wr_addr  = bus.start ? '0 : wr_idx;
   assign complete = bus.in_valid && !bus.start && (wr_idx == LAST);

   always_ff @(posedge clk)
      if (bus.in_valid) mem[{wr_bank, wr_addr}] <= bus.in_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_idx     <= '0;
         wr_bank    <= 1'b0;
         frame_mode <= '0;
      end else begin
         if (bus.in_valid && wr_addr == '0) frame_mode <= bus.mode;
         if (bus.start)
            wr_idx <= bus.in_valid ? LOG2N'(1) : '0;
         else if (bus.in_valid)
            wr_idx <= wr_idx + LOG2N'(1);
         if (complete) wr_bank <= ~wr_bank;
      end
   end

   reorder_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .mode   (rd_mode),
      .rd_idx (rd_idx),
      .addr   (rd_addr)
   );

   // Readout FSM with registered outputs; a completion at rd_idx = N-1 chains frames gaplessly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RD_IDLE;
         rd_idx      <= '0;
         rd_bank     <= 1'b0;
         rd_mode     <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_data_q  <= '0;
      end else if (bus.start) begin
         state       <= RD_IDLE;
         rd_idx      <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
      end else begin
         case (state)
            RD_IDLE: begin
               out_valid_q <= 1'b0;
               out_first_q <= 1'b0;
               if (complete) begin
                  state   <= RD_READ;
                  rd_idx  <= '0;
                  rd_bank <= wr_bank;
                  rd_mode <= frame_mode;
               end
            end
            RD_READ: begin
               out_data_q  <= mem[{rd_bank, rd_addr}];
               out_valid_q <= 1'b1;
               out_first_q <= (rd_idx == '0);
               if (rd_idx == LAST) begin
                  rd_idx <= '0;
                  if (complete) begin
                     rd_bank <= wr_bank;
                     rd_mode <= frame_mode;
                  end else begin
                     state <= RD_IDLE;
                  end
               end else begin
                  rd_idx <= rd_idx + LOG2N'(1);
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_first = out_first_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_stream_reorder.sv
// Directed bench for stream_reorder: per-cycle schedule of expected outputs (DW=16, LOG2N=4).
module tb_stream_reorder;

   localparam int DW  = 16;
   localparam int SZ  = 1024;
`ifdef STREAM_REORDER_BITREV_EN
   localparam int BR_SEL = 2;
`else
   localparam int BR_SEL = 0;
`endif

   logic clk;
   logic reset_n;
   stream_reorder_if #(.DW(DW)) bus ();

   stream_reorder #(.DW(DW), .LOG2N(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   int tab_eo [16] = '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3, 5, 7, 9, 11, 13, 15};
   int tab_br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   bit            exp_v [SZ];
   bit            exp_f [SZ];
   logic [DW-1:0] exp_d [SZ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
   endtask

   task automatic drive(input logic v, input int d, input int m, input logic s);
      bus.in_valid = v;
      bus.in_data  = DW'(d);
      bus.mode     = 2'(m);
      bus.start    = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (exp_v[cyc]) begin
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("out_first", 32'(bus.out_first), 32'(exp_f[cyc]));
         chk("out_data",  32'(bus.out_data),  32'(exp_d[cyc]));
      end else begin
         chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
      end
   endtask

   task automatic expect_frame(input int t_done, input int sel, input int base);
      int p;
      for (int k = 0; k < 16; k++) begin
         p = (sel == 1) ? tab_eo[k] : (sel == 2) ? tab_br[k] : k;
         exp_v[t_done+2+k] = 1'b1;
         exp_f[t_done+2+k] = (k == 0);
         exp_d[t_done+2+k] = DW'(base + p);
      end
   endtask

   task automatic cancel(input int c);
      for (int k = c + 1; k < SZ; k++) exp_v[k] = 1'b0;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 0, 0, 1'b0);
      repeat (n) tick();
   endtask

   initial begin
      for (int k = 0; k < SZ; k++) begin
         exp_v[k] = 1'b0;
         exp_f[k] = 1'b0;
         exp_d[k] = '0;
      end
      drive(1'b0, 0, 0, 1'b0);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_first", 32'(bus.out_first), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      reset_n = 1'b1;
      cyc = 0;

      // mode 0, inputs 0..15 in cycles 0..15 -> outputs in cycles 17..32
      expect_frame(cyc + 15, 0, 0);
      for (int i = 0; i < 16; i++) begin drive(1'b1, i, 0, 1'b0); tick(); end
      idle(20);

      // mode 1 even/odd split
      expect_frame(cyc + 15, 1, 0);
      for (int i = 0; i < 16; i++) begin drive(1'b1, i, 1, 1'b0); tick(); end
      idle(20);

      // mode 2 bit-reverse (pass-through without the feature)
      expect_frame(cyc + 15, BR_SEL, 0);
      for (int i = 0; i < 16; i++) begin drive(1'b1, i, 2, 1'b0); tick(); end
      idle(20);

      // three back-to-back frames, mode wiggled after index 0
      for (int f = 0; f < 3; f++) begin
         expect_frame(cyc + 15, (f == 2) ? BR_SEL : f, 32 + 16*f);
         for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32 + 16*f + i, (i == 0) ? f : 3 - f, 1'b0);
            tick();
         end
      end
      idle(20);

      // in_valid every other cycle, samples 100..115
      expect_frame(cyc + 30, 0, 100);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 100 + i, 0, 1'b0);
         tick();
         if (i < 15) idle(1);
      end
      idle(20);

      // start with a sample at wr_idx 9 of the next frame, mid-readout of the previous one
      expect_frame(cyc + 15, 0, 200);
      for (int i = 0; i < 16; i++) begin drive(1'b1, 200 + i, 0, 1'b0); tick(); end
      for (int i = 0; i < 9; i++) begin drive(1'b1, 300 + i, 0, 1'b0); tick(); end
      cancel(cyc);
      expect_frame(cyc + 15, 1, 400);
      drive(1'b1, 400, 1, 1'b1);
      tick();
      for (int i = 1; i < 16; i++) begin drive(1'b1, 400 + i, 0, 1'b0); tick(); end
      idle(20);

      // async reset pulse mid-frame while a readout is active
      expect_frame(cyc + 15, 0, 500);
      for (int i = 0; i < 16; i++) begin drive(1'b1, 500 + i, 0, 1'b0); tick(); end
      for (int i = 0; i < 6; i++) begin drive(1'b1, 600 + i, 0, 1'b0); tick(); end
      drive(1'b0, 0, 0, 1'b0);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_first", 32'(bus.out_first), 32'd0);
      chk("arst_out_data",  32'(bus.out_data),  32'd0);
      cancel(cyc);
      idle(2);
      reset_n = 1'b1;
      idle(1);

      // normal operation resumes after reset
      expect_frame(cyc + 15, 1, 700);
      for (int i = 0; i < 16; i++) begin drive(1'b1, 700 + i, 1, 1'b0); tick(); end
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
